// File: rtl/match_controller.sv
// Match flow sequencer: start screen, countdown, fight/pause, game over.
// Define SUDDEN_DEATH_EN to restart a drawn match at 1/1 health instead of ending it.
module match_controller #(
    parameter logic [2:0]  MAX_HEALTH   = 3'd5,
    parameter int          COUNT_FRAMES = 60,
    parameter int          IFRAMES      = 30,
    parameter int          OVER_FRAMES  = 180,
    parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
    parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
    parameter logic [31:0] PAUSE_CODE   = 32'h20DF_10EF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] ir_in,
    input  logic        ir_valid_in,
    input  logic        nf_in,
    input  logic        player_hit_in,
    input  logic        opponent_hit_in,
    output logic        display_start_out,
    output logic [2:0]  state_out,
    output logic [1:0]  countdown_out,
    output logic [2:0]  player_health_out,
    output logic [2:0]  opponent_health_out,
    output logic        player_immune_out,
    output logic        opponent_immune_out,
    output logic [1:0]  winner_out
);

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_FIGHT = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int FMAX = (COUNT_FRAMES > OVER_FRAMES) ? COUNT_FRAMES : OVER_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int CW   = $clog2(IFRAMES + 1);

    localparam logic [FW-1:0] COUNT_LAST = FW'(COUNT_FRAMES - 1);
    localparam logic [FW-1:0] OVER_LAST  = FW'(OVER_FRAMES - 1);
    localparam logic [CW-1:0] COOL_LOAD  = CW'(IFRAMES);

    logic [2:0]          state_reg, state_next;
    logic                display_reg, display_next;
    logic [1:0]          countdown_reg, countdown_next;
    logic [FW-1:0]       frame_reg, frame_next;
    logic [1:0][2:0]     health_reg, health_next;
    logic [1:0][CW-1:0]  cool_reg, cool_next;
    logic [1:0]          immune_reg, immune_next;
    logic [1:0]          winner_reg, winner_next;

    // Index 0 is the player, index 1 the opponent throughout.
    logic [1:0]          hit;
    logic [1:0]          accept;
    logic [1:0][2:0]     fight_health;
    logic [1:0][CW-1:0]  fight_cool;
    logic [1:0]          dead;
    logic                start_code;
    logic                pause_code;

    assign hit        = {opponent_hit_in, player_hit_in};
    assign start_code = ir_valid_in && ((ir_in == START_CODE_A) || (ir_in == START_CODE_B));
    assign pause_code = ir_valid_in && (ir_in == PAUSE_CODE);

    // Per-player view of what a FIGHT cycle would do to health and cooldown.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            assign accept[gi] = hit[gi] && (cool_reg[gi] == '0) && (health_reg[gi] != 3'd0);

            assign fight_health[gi] = accept[gi] ? (health_reg[gi] - 3'd1) : health_reg[gi];

            assign fight_cool[gi] = accept[gi]                          ? COOL_LOAD :
                                    (nf_in && (cool_reg[gi] != '0))     ? (cool_reg[gi] - 1'b1) :
                                                                          cool_reg[gi];

            assign dead[gi] = (fight_health[gi] == 3'd0);

            assign immune_next[gi] = (cool_next[gi] != '0);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        display_next   = display_reg;
        countdown_next = countdown_reg;
        frame_next     = frame_reg;
        health_next    = health_reg;
        cool_next      = cool_reg;
        winner_next    = winner_reg;

        case (state_reg)
            S_START: begin
                if (start_code) begin
                    state_next     = S_COUNT;
                    display_next   = 1'b0;
                    countdown_next = 2'd3;
                    frame_next     = '0;
                    health_next    = {MAX_HEALTH, MAX_HEALTH};
                    cool_next      = '0;
                    winner_next    = 2'b00;
                end
            end

            S_COUNT: begin
                if (nf_in) begin
                    if (frame_reg == COUNT_LAST) begin
                        frame_next = '0;
                        if (countdown_reg == 2'd1) begin
                            state_next     = S_FIGHT;
                            countdown_next = 2'd0;
                        end else begin
                            countdown_next = countdown_reg - 2'd1;
                        end
                    end else begin
                        frame_next = frame_reg + 1'b1;
                    end
                end
            end

            S_FIGHT: begin
                health_next = fight_health;
                cool_next   = fight_cool;
                if (dead == 2'b11) begin
`ifdef SUDDEN_DEATH_EN
                    state_next     = S_COUNT;
                    countdown_next = 2'd3;
                    frame_next     = '0;
                    health_next    = {3'd1, 3'd1};
                    cool_next      = '0;
                    winner_next    = 2'b00;
`else
                    state_next  = S_OVER;
                    frame_next  = '0;
                    winner_next = 2'b11;
`endif
                end else if (dead != 2'b00) begin
                    state_next  = S_OVER;
                    frame_next  = '0;
                    winner_next = dead[1] ? 2'b01 : 2'b10;
                end else if (pause_code) begin
                    state_next = S_PAUSE;
                end
            end

            S_PAUSE: begin
                if (pause_code) begin
                    state_next = S_FIGHT;
                end
            end

            S_OVER: begin
                // A start code short-circuits the hold timer.
                if (start_code) begin
                    state_next     = S_COUNT;
                    display_next   = 1'b0;
                    countdown_next = 2'd3;
                    frame_next     = '0;
                    health_next    = {MAX_HEALTH, MAX_HEALTH};
                    cool_next      = '0;
                    winner_next    = 2'b00;
                end else if (nf_in) begin
                    if (frame_reg == OVER_LAST) begin
                        state_next   = S_START;
                        display_next = 1'b1;
                        frame_next   = '0;
                    end else begin
                        frame_next = frame_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next     = S_START;
                display_next   = 1'b1;
                countdown_next = 2'd0;
                frame_next     = '0;
                cool_next      = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= S_START;
            display_reg   <= 1'b1;
            countdown_reg <= 2'd0;
            frame_reg     <= '0;
            health_reg    <= {MAX_HEALTH, MAX_HEALTH};
            cool_reg      <= '0;
            immune_reg    <= 2'b00;
            winner_reg    <= 2'b00;
        end else begin
            state_reg     <= state_next;
            display_reg   <= display_next;
            countdown_reg <= countdown_next;
            frame_reg     <= frame_next;
            health_reg    <= health_next;
            cool_reg      <= cool_next;
            immune_reg    <= immune_next;
            winner_reg    <= winner_next;
        end
    end

    assign display_start_out   = display_reg;
    assign state_out           = state_reg;
    assign countdown_out       = countdown_reg;
    assign player_health_out   = health_reg[0];
    assign opponent_health_out = health_reg[1];
    assign player_immune_out   = immune_reg[0];
    assign opponent_immune_out = immune_reg[1];
    assign winner_out          = winner_reg;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: expected output snapshots are queued
// as stimulus is applied and compared once the DUT has clocked it in.
module tb_match_controller;

    localparam logic [31:0] CODE_A     = 32'h20DF_5BA4;
    localparam logic [31:0] CODE_B     = 32'h20DF_5AA5;
    localparam logic [31:0] CODE_PAUSE = 32'h20DF_10EF;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] ir_in;
    logic        ir_valid_in;
    logic        nf_in;
    logic        player_hit_in;
    logic        opponent_hit_in;
    logic        display_start_out;
    logic [2:0]  state_out;
    logic [1:0]  countdown_out;
    logic [2:0]  player_health_out;
    logic [2:0]  opponent_health_out;
    logic        player_immune_out;
    logic        opponent_immune_out;
    logic [1:0]  winner_out;

    match_controller dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .ir_in               (ir_in),
        .ir_valid_in         (ir_valid_in),
        .nf_in               (nf_in),
        .player_hit_in       (player_hit_in),
        .opponent_hit_in     (opponent_hit_in),
        .display_start_out   (display_start_out),
        .state_out           (state_out),
        .countdown_out       (countdown_out),
        .player_health_out   (player_health_out),
        .opponent_health_out (opponent_health_out),
        .player_immune_out   (player_immune_out),
        .opponent_immune_out (opponent_immune_out),
        .winner_out          (winner_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        string tag;
        int    st;
        int    cd;
        int    ph;
        int    oh;
        int    pi;
        int    oi;
        int    win;
        int    ds;
        bit    imm_care;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   hp;
    int   ho;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input int st, input int cd, input int ph, input int oh,
                            input int pi, input int oi, input int win, input int ds, input bit imm_care);
        exp_t e;
        e.tag = tag; e.st = st; e.cd = cd; e.ph = ph; e.oh = oh;
        e.pi = pi; e.oi = oi; e.win = win; e.ds = ds; e.imm_care = imm_care;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        $display("[%0t] %s: state=%0d cd=%0d health=%0d/%0d immune=%0d/%0d winner=%0d start=%0d",
                 $time, e.tag, state_out, countdown_out, player_health_out, opponent_health_out,
                 player_immune_out, opponent_immune_out, winner_out, display_start_out);
        check_val({e.tag, ".state"},     32'(state_out),           32'(e.st));
        check_val({e.tag, ".countdown"}, 32'(countdown_out),       32'(e.cd));
        check_val({e.tag, ".p_health"},  32'(player_health_out),   32'(e.ph));
        check_val({e.tag, ".o_health"},  32'(opponent_health_out), 32'(e.oh));
        check_val({e.tag, ".winner"},    32'(winner_out),          32'(e.win));
        check_val({e.tag, ".display"},   32'(display_start_out),   32'(e.ds));
        if (e.imm_care) begin
            check_val({e.tag, ".p_immune"}, 32'(player_immune_out),   32'(e.pi));
            check_val({e.tag, ".o_immune"}, 32'(opponent_immune_out), 32'(e.oi));
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_ir(input logic [31:0] code);
        ir_in       = code;
        ir_valid_in = 1'b1;
        tick();
        ir_valid_in = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            nf_in = 1'b1;
            tick();
            nf_in = 1'b0;
            tick();
        end
    endtask

    task automatic hit(input logic p, input logic o);
        player_hit_in   = p;
        opponent_hit_in = o;
        tick();
        player_hit_in   = 1'b0;
        opponent_hit_in = 1'b0;
    endtask

    // Drives the opponent from ho down to 0, waiting out each cooldown.
    task automatic kill_opponent();
        while (ho > 1) begin
            ho--;
            push_exp("kill_hit", 2, 0, hp, ho, 0, 1, 0, 0, 1'b1);
            hit(1'b0, 1'b1);
            pop_check();
            push_exp("kill_cool", 2, 0, hp, ho, 0, 0, 0, 0, 1'b1);
            frames(30);
            pop_check();
        end
        ho = 0;
        push_exp("kill_final", 4, 0, hp, 0, 0, 0, 1, 0, 1'b0);
        hit(1'b0, 1'b1);
        pop_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_in = 1'b1;
        ir_in = 32'd0;
        ir_valid_in = 1'b0;
        nf_in = 1'b0;
        player_hit_in = 1'b0;
        opponent_hit_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        push_exp("reset", 0, 0, 5, 5, 0, 0, 0, 1, 1'b1);
        tick();
        pop_check();

        push_exp("nf_in_start", 0, 0, 5, 5, 0, 0, 0, 1, 1'b1);
        frames(2);
        pop_check();

        push_exp("start_a", 1, 3, 5, 5, 0, 0, 0, 0, 1'b1);
        send_ir(CODE_A);
        pop_check();

        push_exp("cd_59", 1, 3, 5, 5, 0, 0, 0, 0, 1'b1);
        frames(59);
        pop_check();
        push_exp("cd_60", 1, 2, 5, 5, 0, 0, 0, 0, 1'b1);
        frames(1);
        pop_check();
        push_exp("cd_179", 1, 1, 5, 5, 0, 0, 0, 0, 1'b1);
        hit(1'b1, 1'b1);
        frames(119);
        pop_check();
        push_exp("fight", 2, 0, 5, 5, 0, 0, 0, 0, 1'b1);
        frames(1);
        pop_check();

        push_exp("fight_start_code", 2, 0, 5, 5, 0, 0, 0, 0, 1'b1);
        send_ir(CODE_A);
        pop_check();

        push_exp("hit1", 2, 0, 5, 4, 0, 1, 0, 0, 1'b1);
        hit(1'b0, 1'b1);
        pop_check();
        push_exp("cool29", 2, 0, 5, 4, 0, 1, 0, 0, 1'b1);
        frames(29);
        pop_check();
        push_exp("hit_immune", 2, 0, 5, 4, 0, 1, 0, 0, 1'b1);
        hit(1'b0, 1'b1);
        pop_check();
        push_exp("cool30", 2, 0, 5, 4, 0, 0, 0, 0, 1'b1);
        frames(1);
        pop_check();
        push_exp("hit2", 2, 0, 5, 3, 0, 1, 0, 0, 1'b1);
        hit(1'b0, 1'b1);
        pop_check();

        push_exp("pause", 3, 0, 5, 3, 0, 1, 0, 0, 1'b1);
        send_ir(CODE_PAUSE);
        pop_check();
        push_exp("pause_hits", 3, 0, 5, 3, 0, 1, 0, 0, 1'b1);
        hit(1'b1, 1'b1);
        pop_check();
        push_exp("pause_frames", 3, 0, 5, 3, 0, 1, 0, 0, 1'b1);
        frames(100);
        pop_check();
        push_exp("pause_start_code", 3, 0, 5, 3, 0, 1, 0, 0, 1'b1);
        send_ir(CODE_B);
        pop_check();
        push_exp("resume", 2, 0, 5, 3, 0, 1, 0, 0, 1'b1);
        send_ir(CODE_PAUSE);
        pop_check();
        push_exp("resume_cool", 2, 0, 5, 3, 0, 0, 0, 0, 1'b1);
        frames(30);
        pop_check();

        push_exp("p_hit1", 2, 0, 4, 3, 1, 0, 0, 0, 1'b1);
        hit(1'b1, 1'b0);
        pop_check();
        frames(30);
        push_exp("p_hit2", 2, 0, 3, 3, 1, 0, 0, 0, 1'b1);
        hit(1'b1, 1'b0);
        pop_check();
        frames(30);
        push_exp("both_hit1", 2, 0, 2, 2, 1, 1, 0, 0, 1'b1);
        hit(1'b1, 1'b1);
        pop_check();
        frames(30);
        push_exp("both_hit2", 2, 0, 1, 1, 1, 1, 0, 0, 1'b1);
        hit(1'b1, 1'b1);
        pop_check();
        push_exp("pre_draw", 2, 0, 1, 1, 0, 0, 0, 0, 1'b1);
        frames(30);
        pop_check();

`ifdef SUDDEN_DEATH_EN
        push_exp("draw_sudden", 1, 3, 1, 1, 0, 0, 0, 0, 1'b1);
        hit(1'b1, 1'b1);
        pop_check();
        push_exp("count_pause_code", 1, 3, 1, 1, 0, 0, 0, 0, 1'b1);
        send_ir(CODE_PAUSE);
        pop_check();
        push_exp("sudden_fight", 2, 0, 1, 1, 0, 0, 0, 0, 1'b1);
        frames(180);
        pop_check();
        hp = 1;
        ho = 1;
`else
        push_exp("draw_over", 4, 0, 0, 0, 0, 0, 3, 0, 1'b0);
        hit(1'b1, 1'b1);
        pop_check();
        push_exp("over_179", 4, 0, 0, 0, 0, 0, 3, 0, 1'b0);
        frames(179);
        pop_check();
        push_exp("over_180", 0, 0, 0, 0, 0, 0, 3, 1, 1'b0);
        frames(1);
        pop_check();
        push_exp("restart_b", 1, 3, 5, 5, 0, 0, 0, 0, 1'b1);
        send_ir(CODE_B);
        pop_check();
        push_exp("fight2", 2, 0, 5, 5, 0, 0, 0, 0, 1'b1);
        frames(180);
        pop_check();
        hp = 5;
        ho = 5;
`endif

        kill_opponent();
        push_exp("over_return", 0, 0, hp, 0, 0, 0, 1, 1, 1'b0);
        frames(180);
        pop_check();

        push_exp("rematch_a", 1, 3, 5, 5, 0, 0, 0, 0, 1'b1);
        send_ir(CODE_A);
        pop_check();
        push_exp("rematch_fight", 2, 0, 5, 5, 0, 0, 0, 0, 1'b1);
        frames(180);
        pop_check();
        hp = 5;
        ho = 5;
        kill_opponent();
        push_exp("over_hold", 4, 0, 5, 0, 0, 0, 1, 0, 1'b0);
        frames(10);
        pop_check();
        push_exp("over_start_b", 1, 3, 5, 5, 0, 0, 0, 0, 1'b1);
        send_ir(CODE_B);
        pop_check();

        push_exp("count_mid", 1, 3, 5, 5, 0, 0, 0, 0, 1'b1);
        frames(10);
        pop_check();
        #2 rst_in = 1'b1;
        #1;
        push_exp("async_reset", 0, 0, 5, 5, 0, 0, 0, 1, 1'b1);
        pop_check();
        tick();
        rst_in = 1'b0;
        push_exp("post_reset", 0, 0, 5, 5, 0, 0, 0, 1, 1'b1);
        tick();
        pop_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
